// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage handshake bundle: redirect, imem request/response, decode hand-off
interface fetch_stage_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_4;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, id_pc_4
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, id_pc_4
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - rv32 fetch front end: PC, credit-limited imem requests, in-order fetch queue, redirect flush
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pcf_q  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, pcf_rd, pcf_wr;
  logic [CW-1:0] count, outstanding, drop;
  logic [CW:0]   in_use;
  logic          redirect, req_fire, rsp_fire, enq, pop;

  assign redirect = bus.redirect_valid;
  // queued entries plus in-flight requests (including ones to be dropped) share one credit pool
  assign in_use   = {1'b0, count} + {1'b0, outstanding};

  assign bus.imem_req_valid = !rst && !redirect && (in_use < CREDITS);
  assign bus.imem_req_addr  = pc;
  assign bus.id_valid       = !rst && !redirect && (count != '0);
  assign bus.id_inst        = inst_q[rd_ptr];
  assign bus.id_pc          = pc_q[rd_ptr];
  assign bus.id_pc_4        = pc_q[rd_ptr] + 32'd4;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid && (outstanding != '0);
  assign enq      = rsp_fire && (drop == '0) && !redirect;
  assign pop      = bus.id_valid && bus.id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pcf_rd      <= '0;
      pcf_wr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      if (rsp_fire) pcf_rd <= pcf_rd + AW'(1);
      if (req_fire) pcf_wr <= pcf_wr + AW'(1);

      if (req_fire && !rsp_fire)      outstanding <= outstanding + CW'(1);
      else if (!req_fire && rsp_fire) outstanding <= outstanding - CW'(1);

      if (redirect) begin
        pc     <= {bus.redirect_pc[31:2], 2'b00};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        // every request still in flight after this edge belongs to the wrong path
        drop   <= outstanding - CW'(rsp_fire);
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (rsp_fire && drop != '0) drop <= drop - CW'(1);
        if (enq) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (enq && !pop)      count <= count + CW'(1);
        else if (!enq && pop) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_q[wr_ptr] <= bus.imem_rsp_data;
      pc_q[wr_ptr]   <= pcf_q[pcf_rd];
    end
    if (req_fire) pcf_q[pcf_wr] <= pc;
  end

  assert property (@(posedge clk) disable iff (rst) bus.imem_rsp_valid |-> outstanding != '0);
  assert property (@(posedge clk) disable iff (rst) enq |-> count != CW'(DEPTH));
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a randomized in-order imem model
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] pc_4; } exp_t;

  req_t pend[$];
  exp_t exp_q[$];
  logic [31:0] exp_next;
  int lat_min = 1, lat_max = 1, rdy_pct = 100;
  int pops = 0;
  logic [31:0] last_pc = '0;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  // reference stream: after reset or redirect, decode sees target, target+4, ... in order
  task automatic fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{exp_next, hash(exp_next), exp_next + 32'd4});
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] target);
    exp_q.delete();
    exp_next = {target[31:2], 2'b00};
    fill();
  endtask

  // imem: in-order responses with random latency, random request backpressure
  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        pend.delete();
        bus.imem_rsp_valid = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = hash(pend[0].addr);
      end else begin
        bus.imem_rsp_valid = 1'b0;
      end
      bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (rst) pend.delete();
      else begin
        if (bus.imem_rsp_valid) void'(pend.pop_front());
        if (bus.imem_req_valid && bus.imem_req_ready)
          pend.push_back('{bus.imem_req_addr, cyc + $urandom_range(lat_max, lat_min)});
      end
    end
  end

  // monitor: every decode handshake is compared against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.id_valid && bus.id_ready) begin
        e = exp_q.pop_front();
        chk("id_pc", bus.id_pc, e.pc);
        chk("id_inst", bus.id_inst, e.inst);
        chk("id_pc_4", bus.id_pc_4, e.pc_4);
        fill();
        last_pc = bus.id_pc;
        pops++;
      end
    end
  end

  task automatic drive_tick();
    @(posedge clk); #2;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic wait_pop(input string name, input int budget, input logic [31:0] want);
    int p0 = pops;
    int k = 0;
    while (pops == p0 && k < budget) begin
      sample();
      k++;
    end
    chk({name, "_timeout"}, 32'(pops != p0), 32'd1);
    chk(name, last_pc, want);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    restart(target);
  endtask

  initial begin
    int n_req;
    int k;
    int p0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    restart(RST_PC);
    repeat (3) @(posedge clk);

    sample();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, RST_PC);

    // first fetch latency, 1/cycle throughput, PC wrap
    drive_tick(); rst = 1'b0;
    sample();
    chk("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t1_req_addr", bus.imem_req_addr, RST_PC);
    chk("t1_id_valid_c0", 32'(bus.id_valid), 32'd0);
    drive_tick(); sample();
    chk("t1_id_valid_c1", 32'(bus.id_valid), 32'd0);
    drive_tick(); sample();
    chk("t1_id_valid_c2", 32'(bus.id_valid), 32'd1);
    chk("t1_first_pc", bus.id_pc, RST_PC);
    drive_tick(); sample();
    chk("t1_id_valid_c3", 32'(bus.id_valid), 32'd1);
    chk("t1_pc4_wrap", bus.id_pc_4, 32'h0);
    drive_tick(); sample();
    chk("t1_id_valid_c4", 32'(bus.id_valid), 32'd1);
    chk("t1_pc_wrapped", bus.id_pc, 32'h0);

    // credit limit with decode stalled
    drive_tick(); bus.id_ready = 1'b0; do_redirect(32'h0);
    drive_tick(); bus.redirect_valid = 1'b0;
    n_req = 0;
    repeat (10) begin
      sample();
      if (bus.imem_req_valid && bus.imem_req_ready) n_req++;
      drive_tick();
    end
    sample();
    chk("t2_req_count", 32'(n_req), 32'(DEPTH));
    chk("t2_req_valid_full", 32'(bus.imem_req_valid), 32'd0);
    chk("t2_resume_addr", bus.imem_req_addr, 32'h10);
    drive_tick(); bus.id_ready = 1'b1;
    wait_pop("t2_first_pc", 20, 32'h0);

    // redirect with requests in flight and entries queued
    drive_tick(); bus.id_ready = 1'b0; lat_min = 3; lat_max = 3; do_redirect(32'h40);
    drive_tick(); bus.redirect_valid = 1'b0;
    repeat (4) drive_tick();
    do_redirect(32'h0000_0103);
    sample();
    chk("t3_req_valid_redir", 32'(bus.imem_req_valid), 32'd0);
    chk("t3_id_valid_redir", 32'(bus.id_valid), 32'd0);
    drive_tick(); bus.redirect_valid = 1'b0; lat_min = 1; lat_max = 1;
    sample();
    chk("t3_next_addr", bus.imem_req_addr, 32'h100);
    drive_tick(); bus.id_ready = 1'b1;
    wait_pop("t3_first_pc", 30, 32'h100);

    // redirect coinciding with a response, then a second redirect
    lat_min = 1; lat_max = 2;
    k = 0;
    do begin drive_tick(); k++; end while (!bus.imem_rsp_valid && k < 50);
    chk("t4_rsp_seen", 32'(bus.imem_rsp_valid), 32'd1);
    do_redirect(32'h180);
    sample();
    chk("t4_id_valid_redir", 32'(bus.id_valid), 32'd0);
    drive_tick(); do_redirect(32'h200);
    drive_tick(); bus.redirect_valid = 1'b0;
    wait_pop("t4_first_pc", 30, 32'h200);

    // asynchronous reset mid-operation
    drive_tick(); bus.id_ready = 1'b0; lat_min = 2; lat_max = 2; do_redirect(32'h300);
    drive_tick(); bus.redirect_valid = 1'b0;
    repeat (6) drive_tick();
    sample();
    chk("t6_id_valid_before", 32'(bus.id_valid), 32'd1);
    rst = 1'b1;
    restart(RST_PC);
    #1;
    chk("t6_req_valid_rst", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_id_valid_rst", 32'(bus.id_valid), 32'd0);
    repeat (3) drive_tick();
    rst = 1'b0; bus.id_ready = 1'b1; lat_min = 1; lat_max = 1;
    sample();
    chk("t6_restart_addr", bus.imem_req_addr, RST_PC);
    chk("t6_restart_valid", 32'(bus.imem_req_valid), 32'd1);
    wait_pop("t6_first_pc", 20, RST_PC);

    // randomized traffic: backpressure on both sides, variable latency, random redirects
    lat_min = 1; lat_max = 4; rdy_pct = 70;
    p0 = pops;
    for (int i = 0; i < 1500; i++) begin
      drive_tick();
      bus.id_ready = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) do_redirect($urandom());
      else bus.redirect_valid = 1'b0;
      if (bus.redirect_valid) begin
        sample();
        chk("rand_no_req_on_redirect", 32'(bus.imem_req_valid), 32'd0);
      end
    end
    drive_tick(); bus.redirect_valid = 1'b0; bus.id_ready = 1'b1; rdy_pct = 100;
    repeat (30) drive_tick();
    chk("rand_progress", 32'(pops - p0 > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
